// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and register-index constants for the MIPS core.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_AT   = 5'd1;
    localparam reg_idx_t REG_V0   = 5'd2;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_write_decoder.sv
// One-hot write-enable demux for the register file; $zero never gets an enable.
module reg_write_decoder #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]   wr_idx_i,
    input  logic                wr_en_i,
    output logic [NUM_REGS-1:0] we_o
);
    always_comb begin
        we_o = '0;
        if (wr_en_i)
            we_o[wr_idx_i] = 1'b1;
        we_o[0] = 1'b0;
    end
endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: one write port, two operand read ports, one debug port.
// Define REGFILE_BYPASS_EN for write-first forwarding on read_data1/read_data2.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] dbg_reg,
    output logic [DATA_W-1:0] dbg_data
);
    if (NUM_REGS != 2**ADDR_W) begin : g_bad_params
        $error("reg_file: NUM_REGS must equal 2**ADDR_W");
    end

    logic [NUM_REGS-1:0]             we;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]               stored1, stored2;

    reg_write_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_dec (
        .wr_idx_i(write_reg),
        .wr_en_i (reg_write),
        .we_o    (we)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++)
            if (we[i])
                regs_d[i] = write_data;
    end

    // Reset wins over a same-edge write, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    // Index 0 is masked so $zero reads 0 even before the first reset.
    assign stored1  = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
    assign stored2  = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
    assign dbg_data = (dbg_reg   == '0) ? '0 : regs_q[dbg_reg];

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live    = reg_write && (write_reg != '0);
    assign read_data1 = (wr_live && read_reg1 == write_reg) ? write_data : stored1;
    assign read_data2 = (wr_live && read_reg2 == write_reg) ? write_data : stored2;
`else
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table plus hand-written corner sequences.
module tb_reg_file;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n, reg_write;
    reg_idx_t write_reg, read_reg1, read_reg2, dbg_reg;
    word_t    write_data, read_data1, read_data2, dbg_data;

    always #5 clk = ~clk;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_write (reg_write),
        .write_reg (write_reg),
        .write_data(write_data),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .dbg_reg   (dbg_reg),
        .dbg_data  (dbg_data)
    );

    typedef struct {
        string name;
        word_t e1, e2, ed;
    } exp_t;

    typedef struct {
        string    name;
        logic     rst, we;
        reg_idx_t wreg;
        word_t    wdata;
        reg_idx_t r1, r2, rd;
        word_t    e1, e2, ed;
    } vec_t;

    exp_t  sb[$];
    word_t model [32];
    int    checks = 0;
    int    errors = 0;

    task automatic cmp(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Push expected, let the combinational read settle, then pop and compare.
    task automatic check_rd(string name, reg_idx_t r1, reg_idx_t r2, reg_idx_t rd,
                            word_t e1, word_t e2, word_t ed);
        exp_t x;
        read_reg1 = r1;
        read_reg2 = r2;
        dbg_reg   = rd;
        sb.push_back('{name, e1, e2, ed});
        #1;
        x = sb.pop_front();
        cmp({x.name, ".rd1"}, read_data1, x.e1);
        cmp({x.name, ".rd2"}, read_data2, x.e2);
        cmp({x.name, ".dbg"}, dbg_data,   x.ed);
    endtask

    task automatic step(logic rst, logic we, reg_idx_t wreg, word_t wdata);
        @(negedge clk);
        rst_n      = rst;
        reg_write  = we;
        write_reg  = wreg;
        write_data = wdata;
        @(posedge clk);
        if (!rst)
            foreach (model[i]) model[i] = '0;
        else if (we && wreg != 0)
            model[wreg] = wdata;
        #1;
        rst_n     = 1'b1;
        reg_write = 1'b0;
    endtask

    task automatic check_all(string name);
        for (int i = 0; i < 32; i++)
            check_rd(name, reg_idx_t'(i), reg_idx_t'(31 - i), reg_idx_t'(i),
                     model[i], model[31 - i], model[i]);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"wr8",    1, 1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9, 5'd8,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{"wr5",    1, 1, 5'd5,  32'h00000055, 5'd5,  5'd8, 5'd0,  32'h55, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{"we_off", 1, 0, 5'd5,  32'h12345678, 5'd5,  5'd5, 5'd5,  32'h55, 32'h55, 32'h55};
        vecs[3] = '{"zero",   1, 1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0, 5'd0,  32'h0, 32'h0, 32'h0};
        vecs[4] = '{"wr31",   1, 1, 5'd31, 32'h00000001, 5'd31, 5'd8, 5'd31, 32'h1, 32'hDEADBEEF, 32'h1};
        vecs[5] = '{"rst_wr", 0, 1, 5'd3,  32'hAAAA5555, 5'd3,  5'd8, 5'd31, 32'h0, 32'h0, 32'h0};

        foreach (model[i]) model[i] = '0;
        rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; dbg_reg = '0;

        // Initial reset, some random writes, then reset held for two edges.
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step(1, 1, reg_idx_t'($urandom_range(1, 31)), $urandom);
        step(0, 1, 5'd7, 32'h77777777);
        step(0, 0, 0, 0);
        check_all("reset");

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].we, vecs[k].wreg, vecs[k].wdata);
            check_rd(vecs[k].name, vecs[k].r1, vecs[k].r2, vecs[k].rd,
                     vecs[k].e1, vecs[k].e2, vecs[k].ed);
            if (vecs[k].name == "zero")
                check_all("zero_others");
        end

        // Same-cycle read/write of reg 31: old 1, new 2.
        step(1, 1, 5'd31, 32'h1);
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h2;
`ifdef REGFILE_BYPASS_EN
        check_rd("same_cyc_pre", 5'd31, 5'd31, 5'd31, 32'h2, 32'h2, 32'h1);
`else
        check_rd("same_cyc_pre", 5'd31, 5'd31, 5'd31, 32'h1, 32'h1, 32'h1);
`endif
        @(posedge clk);
        model[31] = 32'h2;
        #1;
        reg_write = 1'b0;
        check_rd("same_cyc_post", 5'd31, 5'd0, 5'd31, 32'h2, 32'h0, 32'h2);

        // Sweep every writable index with distinct data to expose aliasing.
        for (int i = 1; i < 32; i++)
            step(1, 1, reg_idx_t'(i), 32'h1000_0000 + word_t'(i) * 32'h0001_0203);
        check_all("sweep");

        step(0, 0, 0, 0);
        check_all("reset_again");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
